// File: rtl/spi_slave_word.sv
// SPI slave with word-wide receive and transmit registers. Every bus input is
// resynchronised into clk, so sclk must run well below the clk rate.
module spi_slave_word #(
  parameter int WIDTH     = 8,
  parameter int SS_ACTIVE = 1,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_err,
  output logic             busy
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic          IDLE = (CPOL != 0);
  localparam logic          ACT  = (SS_ACTIVE != 0);
  localparam logic          PH1  = (CPHA != 0);
  localparam logic          MSBF = (MSB_FIRST != 0);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]       sclk_sync;
  logic [1:0]       ss_sync;
  logic [1:0]       mosi_sync;
  logic             sel, sel_q;
  logic             lead, trail, sample_edge, drive_edge;
  logic             activate, deselect, load_ev, tx_accept;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-2:0] rx_keep;
  logic [WIDTH-1:0] tx_hold;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_next;
  logic             tx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= {3{IDLE}};
      ss_sync   <= {2{~ACT}};
      mosi_sync <= '0;
      sel_q     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      ss_sync   <= {ss_sync[0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
      sel_q     <= sel;
    end
  end

  assign sel         = (ss_sync[1] == ACT);
  assign lead        = sel && (sclk_sync[2] == IDLE) && (sclk_sync[1] != IDLE);
  assign trail       = sel && (sclk_sync[2] != IDLE) && (sclk_sync[1] == IDLE);
  assign sample_edge = PH1 ? trail : lead;
  assign drive_edge  = PH1 ? lead : trail;
  assign activate    = sel && !sel_q;
  assign deselect    = !sel && sel_q;
  assign tx_accept   = tx_load && tx_ready;

  // A drive edge with the counter at zero opens a new word in both phases; in
  // phase 0 the first bit must already be on miso when ss goes active.
  assign load_ev = (drive_edge && (bit_cnt == '0)) || (!PH1 && activate);

  always_comb begin
    if (MSBF) begin
      rx_next = {rx_shift, mosi_sync[1]};
      rx_keep = rx_next[WIDTH-2:0];
      tx_next = {tx_shift[WIDTH-2:0], 1'b0};
      tx_bit  = tx_shift[WIDTH-1];
    end else begin
      rx_next = {mosi_sync[1], rx_shift};
      rx_keep = rx_next[WIDTH-1:1];
      tx_next = {1'b0, tx_shift[WIDTH-1:1]};
      tx_bit  = tx_shift[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (deselect) begin
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_keep;
        if (bit_cnt == LAST) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  // tx_ready doubles as the "holding register empty" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold     <= '0;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (load_ev) begin
        tx_shift    <= tx_ready ? '0 : tx_hold;
        tx_underrun <= tx_ready;
        tx_ready    <= !tx_accept;
        if (tx_accept) tx_hold <= tx_data;
      end else begin
        if (drive_edge) tx_shift <= tx_next;
        if (tx_accept) begin
          tx_hold  <= tx_data;
          tx_ready <= 1'b0;
        end
      end
    end
  end

  assign miso = sel && tx_bit;
  assign busy = sel;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: a mode-0 MSB-first 8-bit slave and a mode-3
// LSB-first 16-bit slave with active-low select share one SPI master.
module tb_spi_slave_word;

  typedef struct {
    int          d;
    int          nw;
    int          ab;
    bit          pre;
    logic [31:0] txw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] m0;
    int          ur;
    int          fe;
  } vec_t;

  logic        clk, rst, sclk, mosi, ss0, ss1;
  logic        miso0, rx_valid0, tx_load0, tx_ready0, tx_underrun0, frame_err0, busy0;
  logic        miso1, rx_valid1, tx_load1, tx_ready1, tx_underrun1, frame_err1, busy1;
  logic [7:0]  rx_data0, tx_data0;
  logic [15:0] rx_data1, tx_data1;

  int          n_vec = 0;
  int          n_err = 0;
  int          ur_cnt = 0;
  int          fe_cnt = 0;
  logic [31:0] rxq[$];
  vec_t        tbl[8];

  spi_slave_word u0 (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss0), .mosi(mosi), .miso(miso0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(tx_data0), .tx_load(tx_load0),
    .tx_ready(tx_ready0), .tx_underrun(tx_underrun0), .frame_err(frame_err0), .busy(busy0)
  );

  spi_slave_word #(.WIDTH(16), .SS_ACTIVE(0), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss1), .mosi(mosi), .miso(miso1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_data(tx_data1), .tx_load(tx_load1),
    .tx_ready(tx_ready1), .tx_underrun(tx_underrun1), .frame_err(frame_err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // Pulse monitor; only one slave is selected at a time.
  always @(negedge clk) begin
    if (rx_valid0) rxq.push_back(32'(rx_data0));
    if (rx_valid1) rxq.push_back(32'(rx_data1));
    if (tx_underrun0) ur_cnt++;
    if (tx_underrun1) ur_cnt++;
    if (frame_err0) fe_cnt++;
    if (frame_err1) fe_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".rx_data0"}, 32'(rx_data0), 32'h0);
    chk({tag, ".flags0"}, 32'({rx_valid0, tx_ready0, tx_underrun0, frame_err0, busy0, miso0}), 32'b010000);
    chk({tag, ".rx_data1"}, 32'(rx_data1), 32'h0);
    chk({tag, ".flags1"}, 32'({rx_valid1, tx_ready1, tx_underrun1, frame_err1, busy1, miso1}), 32'b010000);
  endtask

  // Holding register holds one word; every load event either consumes it or
  // underruns. Phase 0 loads at select and after each word, phase 1 at the
  // start of each word; an aborted word has seen exactly one load event.
  function automatic int model_ur(input int d, input int nw, input int ab, input bit pre);
    int loads;
    if (ab != 0) loads = 1;
    else         loads = (d == 0) ? nw + 1 : nw;
    return loads - (pre ? 1 : 0);
  endfunction

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic load(input int d, input logic [31:0] val);
    @(negedge clk);
    if (d == 0) begin tx_data0 = val[7:0];  tx_load0 = 1'b1; end
    else        begin tx_data1 = val[15:0]; tx_load1 = 1'b1; end
    @(negedge clk);
    tx_load0 = 1'b0;
    tx_load1 = 1'b0;
  endtask

  task automatic xfer_bits(input int d, input logic [31:0] w, input int nbits, output logic [31:0] got);
    int width, b;
    logic cpol, cpha, msb;
    width = (d != 0) ? 16 : 8;
    cpol  = (d != 0);
    cpha  = (d != 0);
    msb   = (d == 0);
    got   = '0;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? width - 1 - i : i;
      if (!cpha) begin
        mosi = w[b];
        half();
        got[b] = (d != 0) ? miso1 : miso0;
        sclk = ~cpol;
        half();
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = w[b];
        half();
        got[b] = (d != 0) ? miso1 : miso0;
        sclk = cpol;
        half();
      end
    end
  endtask

  task automatic run_frame(input vec_t v, output logic [31:0] g0, output logic [31:0] g1,
                           output logic [31:0] g2);
    int          width;
    logic [31:0] w, g;
    width = (v.d != 0) ? 16 : 8;
    g0 = '0; g1 = '0; g2 = '0;
    sclk = (v.d != 0);
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    if (v.d == 0) ss0 = 1'b1; else ss1 = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < v.nw; k++) begin
      w = (k == 0) ? v.w0 : (k == 1) ? v.w1 : v.w2;
      xfer_bits(v.d, w, (v.ab != 0) ? v.ab : width, g);
      if (k == 0) g0 = g; else if (k == 1) g1 = g; else g2 = g;
    end
    half();
    ss0 = 1'b0;
    ss1 = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] g0, g1, g2, mask, w;
    int          nrx;
    mask = (v.d == 0) ? 32'hFF : 32'hFFFF;
    @(negedge clk);
    rxq.delete();
    ur_cnt = 0;
    fe_cnt = 0;
    if (v.pre) begin
      load(v.d, v.txw);
      chk({tag, ".ready_after_load"}, 32'((v.d == 0) ? tx_ready0 : tx_ready1), 32'h0);
    end
    run_frame(v, g0, g1, g2);
    nrx = (v.ab != 0) ? 0 : v.nw;
    chk({tag, ".rx_count"}, 32'(rxq.size()), 32'(nrx));
    for (int k = 0; k < nrx && k < rxq.size(); k++) begin
      w = (k == 0) ? v.w0 : (k == 1) ? v.w1 : v.w2;
      chk({tag, ".rx_word"}, rxq[k], w & mask);
    end
    if (v.ab == 0) begin
      chk({tag, ".miso_w0"}, g0, v.m0 & mask);
      if (v.nw > 1) chk({tag, ".miso_w1"}, g1, 32'h0);
      if (v.nw > 2) chk({tag, ".miso_w2"}, g2, 32'h0);
    end
    chk({tag, ".underruns"}, 32'(ur_cnt), 32'(v.ur));
    chk({tag, ".frame_errs"}, 32'(fe_cnt), 32'(v.fe));
    chk({tag, ".ready_end"}, 32'((v.d == 0) ? tx_ready0 : tx_ready1), 32'h1);
    chk({tag, ".busy_end"}, 32'((v.d == 0) ? busy0 : busy1), 32'h0);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] g, mask;
    int          width;

    //          d  nw ab pre txw        w0         w1         w2      m0         ur fe
    tbl[0] = '{0, 1, 0, 1, 32'hA5,   32'h3C,   32'h0,    32'h0,  32'hA5,   1, 0};
    tbl[1] = '{0, 1, 0, 0, 32'h00,   32'h55,   32'h0,    32'h0,  32'h00,   2, 0};
    tbl[2] = '{0, 1, 5, 0, 32'h00,   32'h1F,   32'h0,    32'h0,  32'h00,   1, 1};
    tbl[3] = '{0, 1, 0, 1, 32'h5A,   32'h81,   32'h0,    32'h0,  32'h5A,   1, 0};
    tbl[4] = '{1, 2, 0, 1, 32'hC3A5, 32'h1234, 32'hBEEF, 32'h0,  32'hC3A5, 1, 0};
    tbl[5] = '{1, 1, 7, 0, 32'h0,    32'hAAAA, 32'h0,    32'h0,  32'h0,    1, 1};
    tbl[6] = '{1, 1, 0, 0, 32'h0,    32'hFFFF, 32'h0,    32'h0,  32'h0,    1, 0};
    tbl[7] = '{0, 3, 0, 1, 32'h0F,   32'hC3,   32'h7E,   32'h99, 32'h0F,   3, 0};

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss0 = 1'b0; ss1 = 1'b1;
    tx_load0 = 1'b0; tx_load1 = 1'b0; tx_data0 = '0; tx_data1 = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Second load while the holding register is full is dropped.
    load(0, 32'h11);
    tx_data0 = 8'h22;
    tx_load0 = 1'b1;
    @(negedge clk);
    tx_load0 = 1'b0;
    chk("dbl_load.ready", 32'(tx_ready0), 32'h0);
    v = '{0, 1, 0, 0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h11, 1, 0};
    apply(v, "dbl_load");

    // Reset in the middle of a word.
    rxq.delete();
    ur_cnt = 0;
    fe_cnt = 0;
    load(0, 32'h96);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    ss0 = 1'b1;
    repeat (8) @(negedge clk);
    xfer_bits(0, 32'hFF, 3, g);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    ss0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst.no_frame_err", 32'(fe_cnt), 32'h0);
    chk("mid_rst.no_rx", 32'(rxq.size()), 32'h0);
    chk("mid_rst.rx_hold", 32'(rx_data0), 32'h0);
    v = '{0, 1, 0, 1, 32'h3C, 32'hFF, 32'h0, 32'h0, 32'h3C, 1, 0};
    apply(v, "after_rst");

    for (int i = 0; i < 16; i++) begin
      v.d   = int'($urandom_range(0, 1));
      width = (v.d != 0) ? 16 : 8;
      mask  = (v.d != 0) ? 32'hFFFF : 32'hFF;
      v.nw  = int'($urandom_range(1, 3));
      v.ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, width - 1)) : 0;
      if (v.ab != 0) v.nw = 1;
      v.pre = ($urandom_range(0, 1) != 0);
      v.txw = $urandom & mask;
      v.w0  = $urandom & mask;
      v.w1  = $urandom & mask;
      v.w2  = $urandom & mask;
      v.m0  = v.pre ? v.txw : 32'h0;
      v.ur  = model_ur(v.d, v.nw, v.ab, v.pre);
      v.fe  = (v.ab != 0) ? 1 : 0;
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_word.md
SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (2..32).
REQ-002 Parameter SS_ACTIVE, default 1, level of ss that selects the slave.
REQ-003 Parameter CPOL, default 0, idle level of sclk.
REQ-004 Parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 Parameter MSB_FIRST, default 1, 1 = MSB shifted first, 0 = LSB first.
REQ-006 clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 sclk, ss, mosi  input  1 each  SPI bus inputs, asynchronous to clk.
REQ-009 miso  output  1  serial data to master.
REQ-010 rx_data  output  WIDTH  last complete received word.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 tx_data  input  WIDTH  word to transmit; tx_load  input  1  write strobe.
REQ-013 tx_ready  output  1  transmit holding register empty.
REQ-014 tx_underrun  output  1  one-cycle pulse, word started with empty holding register.
REQ-015 frame_err  output  1  one-cycle pulse, ss deasserted mid-word.
REQ-016 busy  output  1  synchronised ss at SS_ACTIVE.

Function
REQ-017 sclk, ss, mosi SHALL each pass through a 2-flop synchroniser; edge detection uses a third flop on sclk.
REQ-018 Leading edge = synced sclk leaving CPOL; trailing edge = returning to CPOL; edges ignored while ss inactive.
REQ-019 Sample edge = leading if CPHA=0, trailing if CPHA=1; drive edge = the other.
REQ-020 Each sample edge SHALL shift mosi into the receive shift register (MSB_FIRST selects direction) and increment a bit counter 0..WIDTH-1 that wraps to 0.
REQ-021 On the sample edge with counter = WIDTH-1, rx_data SHALL load the full word and rx_valid SHALL pulse high the next clk cycle.
REQ-022 rx_data SHALL hold its value until the next complete word; no handshake, overwritten unconditionally.
REQ-023 tx_load with tx_ready=1 SHALL write tx_data into the holding register and clear tx_ready next cycle; tx_load with tx_ready=0 SHALL be ignored.
REQ-024 Load event (holding -> transmit shift register, tx_ready set): CPHA=0 at ss activation and at the drive edge following the last sample of a word; CPHA=1 at the drive edge with counter = 0.
REQ-025 Load event with holding empty SHALL load all-zeros and pulse tx_underrun.
REQ-026 tx_load in the same cycle as a load event SHALL fill the holding register for the following word, not the current one.
REQ-027 miso SHALL present the transmit shift register end bit (MSB or LSB per MSB_FIRST); each non-load drive edge shifts by one, zero fill.
REQ-028 miso SHALL be 0 while ss inactive.
REQ-029 ss deassert with counter != 0 SHALL discard the partial word, reset counter to 0, pulse frame_err, no rx_valid.
REQ-030 ss deassert SHALL not flush the holding register; a loaded but unsent word stays for the next frame.
REQ-031 sclk high and low phases SHALL each be at least 4 clk periods for correct operation.
REQ-032 Latency from bus sample edge to rx_valid SHALL be at most 5 clk cycles.

Reset
REQ-033 While rst=1: rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_err=0, busy=0, miso=0, counter=0, synchronisers cleared to idle (sclk=CPOL, ss inactive).
REQ-034 rst asserted mid-word SHALL abort the word with no rx_valid or frame_err pulse; first frame after release starts at bit 0.

Verification
REQ-035 Defaults, tx_load 0xA5, master sends 0x3C mode 0 -> rx_valid once, rx_data=0x3C, master receives 0xA5, tx_ready=1 after load.
REQ-036 WIDTH=16, CPOL=1 CPHA=1 MSB_FIRST=0, two back-to-back words 0x1234, 0xBEEF in one frame -> two rx_valid pulses with those values in order.
REQ-037 No tx_load before frame -> tx_underrun pulse at first load event, master receives 0x00.
REQ-038 ss deasserted after 5 of 8 bits -> frame_err pulse, no rx_valid; next full frame 0x81 -> rx_data=0x81.
REQ-039 rst pulsed after 3 bits -> all outputs at reset values; next frame 0xFF received correctly.
REQ-040 tx_load twice before frame (0x11 then 0x22) -> second ignored, master receives 0x11.
